// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/synchroniser input-conditioning stage.
package debounce_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 50000;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    WAIT_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    WAIT_LOW    = 2'b10
  } dbnc_state_e;

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level; resets to 0.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronise and debounce a raw asynchronous level; emits a clean level plus
// registered one-cycle rise/fall pulses.
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic s;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (s)
  );

  dbnc_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 dout_q, dout_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        dout_d = 1'b0;
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_HIGH: begin
        dout_d = 1'b0;
        if (!s) begin
          // Candidate did not hold: discard silently.
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HIGH;
          dout_d  = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        dout_d = 1'b1;
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      WAIT_LOW: begin
        dout_d = 1'b1;
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LOW;
          dout_d  = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
        dout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout = dout_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_debounce_sync;

  logic clk = 1'b0;
  logic reset;
  logic din;
  logic dout, rise, fall, busy;

  int n_checks = 0;
  int n_pass   = 0;

  debounce_sync #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout),
    .rise (rise),
    .fall (fall),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din   = 1'b1;
    #1;
    n_checks++;
    if ({dout, rise, fall, busy} !== 4'b0000)
      $display("FAIL reset_immediate: got dout/rise/fall/busy=%b want 0000", {dout, rise, fall, busy});
    else n_pass++;
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (rise !== (e == 6) || dout !== (e >= 6) || fall !== 1'b0 || busy !== (e >= 3 && e <= 5))
        $display("FAIL reset_release e%0d: got r/f/d/b=%b%b%b%b want %b0%b%b", e, rise, fall, dout, busy,
                 (e == 6), (e >= 6), (e >= 3 && e <= 5));
      else n_pass++;
    end
  endtask

  // Precondition: STABLE_HIGH with din=1. Leaves STABLE_LOW, din=0.
  task automatic test_release();
    din = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (fall !== (e == 6) || rise !== 1'b0 || dout !== (e < 6) || busy !== (e >= 3 && e <= 5))
        $display("FAIL release e%0d: got r/f/d/b=%b%b%b%b want 0%b%b%b", e, rise, fall, dout, busy,
                 (e == 6), (e < 6), (e >= 3 && e <= 5));
      else n_pass++;
    end
  endtask

  // Precondition: STABLE_LOW with din=0. Leaves STABLE_HIGH, din=1.
  task automatic test_clean_press();
    din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (rise !== (e == 6) || fall !== 1'b0 || dout !== (e >= 6) || busy !== (e >= 3 && e <= 5))
        $display("FAIL clean_press e%0d: got r/f/d/b=%b%b%b%b want %b0%b%b", e, rise, fall, dout, busy,
                 (e == 6), (e >= 6), (e >= 3 && e <= 5));
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 8; e++) begin
      din = (e == 1);
      step();
      n_checks++;
      if (rise !== 1'b0 || fall !== 1'b0 || dout !== 1'b0 || busy !== (e == 3))
        $display("FAIL glitch e%0d: got r/f/d/b=%b%b%b%b want 000%b", e, rise, fall, dout, busy, (e == 3));
      else n_pass++;
    end
  endtask

  // din: 1,1,0 then 1 held; final rising edge is settled at e=4, so rise at e=9.
  task automatic test_bounce();
    logic exp_busy;
    for (int e = 1; e <= 11; e++) begin
      din = (e != 3);
      step();
      exp_busy = (e == 3) || (e == 4) || (e >= 6 && e <= 8);
      n_checks++;
      if (rise !== (e == 9) || fall !== 1'b0 || dout !== (e >= 9) || busy !== exp_busy)
        $display("FAIL bounce e%0d: got r/f/d/b=%b%b%b%b want %b0%b%b", e, rise, fall, dout, busy,
                 (e == 9), (e >= 9), exp_busy);
      else n_pass++;
    end
  endtask

  // Precondition: STABLE_LOW with din=0.
  task automatic test_reset_mid();
    din = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    n_checks++;
    if (busy !== 1'b1 || dout !== 1'b0)
      $display("FAIL mid_waiting: got busy=%b dout=%b want busy=1 dout=0", busy, dout);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({dout, rise, fall, busy} !== 4'b0000)
      $display("FAIL mid_async_reset: got dout/rise/fall/busy=%b want 0000", {dout, rise, fall, busy});
    else n_pass++;
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if (rise !== (e == 6) || fall !== 1'b0 || dout !== (e >= 6) || busy !== (e >= 3 && e <= 5))
        $display("FAIL mid_requalify e%0d: got r/f/d/b=%b%b%b%b want %b0%b%b", e, rise, fall, dout, busy,
                 (e == 6), (e >= 6), (e >= 3 && e <= 5));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_clean_press();
    test_release();
    test_bounce();
    test_release();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/debounce_sync.md
# debounce_sync

Input-conditioning stage ahead of the team's reset-able D flip-flop register. Takes a raw asynchronous level (push-button, switch, external strobe), synchronises it into the `clk` domain and debounces it. Drives a clean registered level `dout`, which feeds the flip-flop's D input directly, plus single-cycle `rise`/`fall` pulses for downstream event logic.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: number of synchroniser flops. Legal values are 2 or more.
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive identical synchronised samples required to accept a new level. Legal values are 2 or more.
- `CNT_WIDTH`, default 16: counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES-1.

Ports:
- `clk`  input  1  clock
- `reset`  input  1  asynchronous, active-high reset
- `din`  input  1  raw asynchronous level; may change at any time
- `dout`  output  1  debounced, registered level
- `rise`  output  1  one-cycle pulse on the cycle `dout` goes 0→1
- `fall`  output  1  one-cycle pulse on the cycle `dout` goes 1→0
- `busy`  output  1  high while a candidate transition is being qualified

## Operation
- Synchroniser:
  - Chain of `SYNC_STAGES` flops on `din`.
  - The last stage is `s`.
  - No other logic reads `din`.
- FSM states, 2-bit: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW.
- STABLE_LOW:
  - If `s==1`, go to WAIT_HIGH with `cnt<=1`.
  - Otherwise stay, with `cnt<=0`.
- WAIT_HIGH:
  - If `s==0`, return to STABLE_LOW with `cnt<=0`. This is a glitch: no output change.
  - Else if `cnt==DEBOUNCE_CYCLES-1`, go to STABLE_HIGH with `dout<=1`, `rise<=1`, `cnt<=0`.
  - Otherwise `cnt<=cnt+1`.
- STABLE_HIGH and WAIT_LOW mirror the two states above, with `s` polarity inverted. Acceptance sets `dout<=0` and `fall<=1`.
- `rise` and `fall` are registered. They are high for exactly one cycle and are never high together.
- `busy` is high exactly when the state is WAIT_HIGH or WAIT_LOW. It is decoded combinationally from the state register.
- Counter:
  - Unsigned, `CNT_WIDTH` bits.
  - Never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around occurs.
- `dout` always equals the stable-state polarity: 0 in STABLE_LOW/WAIT_HIGH, 1 in STABLE_HIGH/WAIT_LOW.

## Timing
- Reset values, applied immediately and asynchronously:
  - All sync flops 0.
  - State STABLE_LOW, `cnt` 0.
  - `dout`, `rise` and `fall` 0; `busy` 0.
- Reset release: the first active edge after `reset` falls performs normal operation.
- Reset mid-qualification: the pending candidate is discarded with no pulse, and the block re-qualifies from STABLE_LOW.
- Synchronisation latency: `s` follows `din` `SYNC_STAGES` edges after `din` is settled at an edge.
- Debounce latency:
  - `dout` and the pulse update on the `DEBOUNCE_CYCLES`-th edge after `s` changes, provided `s` holds.
  - Total: `SYNC_STAGES + DEBOUNCE_CYCLES` edges from `din` to `dout`.
- Any opposite sample of `s` during WAIT restarts qualification. The next change of `s` begins a fresh count from 1.
- `din` held constant produces no pulses and keeps `busy` at 0.

## Structure
- Shared package `debounce_pkg`:
  - State encoding localparams: STABLE_LOW=2'b00, WAIT_HIGH=2'b01, STABLE_HIGH=2'b11, WAIT_LOW=2'b10.
  - Default `DEBOUNCE_CYCLES` constant.
- Sub-module `sync_chain`:
  - Parameterised `SYNC_STAGES`.
  - Async-reset to 0.
  - Reusable for other asynchronous inputs.
- Top level: FSM, counter, and output registers in a single async-reset `always` block, plus the `busy` decode.

## Test plan
All scenarios use SYNC_STAGES=2 and DEBOUNCE_CYCLES=4.
- Reset check: assert `reset` with `din=1` held → `dout=0`, `rise=0`, `fall=0`, `busy=0` immediately. After release, `rise` pulses exactly 6 edges later and `dout=1`.
- Clean press: `din` 0→1 and held → `busy` high from edge 3. `dout=1` and one-cycle `rise` at edge 6. `fall` never asserts.
- Bounce rejection: `din` high for 2 cycles, low for 1, then high and held → no pulse during the bounce. `rise` fires exactly 6 edges after the final 0→1.
- Glitch: 1-cycle high pulse on `din` in STABLE_LOW → `busy` high for 1 cycle. `dout` stays 0 with no `rise`.
- Release: from STABLE_HIGH, `din` 1→0 and held → `fall` pulses once at edge 6 and `dout=0`. `rise` and `fall` are never both high.
- Reset mid-qualification: assert `reset` during WAIT_HIGH (`cnt=2`) → all outputs 0 asynchronously. After release with `din=1`, a full 6-edge qualification precedes `rise`.
